// File: rtl/fifo_word_reader_pkg.sv
// Shared constants and state encoding for the FIFO word reader.
package fifo_word_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_word_reader.sv
// Drains a byte FIFO, packs bytes little-endian into words and streams them
// out on valid/ready; partial words leave on idle timeout or flush.
module fifo_word_reader
  import fifo_word_reader_pkg::*;
#(
  parameter int unsigned BYTES   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TCW     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  input  logic [BYTE_W-1:0]         fifo_data,
  output logic                      fifo_rd,
  input  logic                      flush,
  output logic [BYTE_W*BYTES-1:0]   m_data,
  output logic [BYTES-1:0]          m_keep,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int unsigned WORD_W   = BYTE_W * BYTES;
  localparam int unsigned CNT_W    = $clog2(BYTES + 1);
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [TCW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                flush_lat_q, flush_lat_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTES-1:0]    keep_q, keep_d;
  logic                m_valid_q, m_valid_d;
  logic                tmo_inc, tmo_fire, emit;

  // Reads stop once the bytes already owned (captured + in flight) fill a word.
  assign fifo_rd = (state_q == FILL) && !fifo_empty && !flush_lat_q &&
                   ((SUM_W'(byte_cnt_q) + SUM_W'(rd_pend_q)) < SUM_W'(BYTES));

  assign tmo_inc  = (state_q == FILL) && (byte_cnt_q != '0) && !rd_pend_q && fifo_empty;
  assign tmo_fire = TMO_EN && tmo_inc && (tmo_cnt_q == TCW'(TMO_LAST));

  assign m_data  = word_q;
  assign m_keep  = keep_q;
  assign m_valid = m_valid_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    rd_pend_d   = fifo_rd && !fifo_empty;
    tmo_cnt_d   = tmo_cnt_q;
    flush_lat_d = flush_lat_q;
    word_d      = word_q;
    keep_d      = keep_q;
    m_valid_d   = m_valid_q;
    emit        = 1'b0;

    case (state_q)
      FILL: begin
        flush_lat_d = flush_lat_q || flush;
        if (rd_pend_q) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
              word_d[i*BYTE_W +: BYTE_W] = fifo_data;
              keep_d[i]                  = 1'b1;
            end
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          tmo_cnt_d  = '0;
        end else if (tmo_inc) begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end

        // A capture in flight always lands before any partial emit.
        if (byte_cnt_d == CNT_W'(BYTES)) begin
          emit = 1'b1;
        end else if (!rd_pend_q && (byte_cnt_q != '0) && (tmo_fire || flush_lat_q)) begin
          emit = 1'b1;
        end else if (!rd_pend_q && flush_lat_q) begin
          flush_lat_d = flush;
        end

        if (emit) begin
          state_d     = OUT;
          m_valid_d   = 1'b1;
          flush_lat_d = 1'b0;
          tmo_cnt_d   = '0;
        end
      end

      OUT: begin
        if (m_ready) begin
          state_d    = FILL;
          m_valid_d  = 1'b0;
          word_d     = '0;
          keep_d     = '0;
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      byte_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      flush_lat_q <= 1'b0;
      word_q      <= '0;
      keep_q      <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_pend_q   <= rd_pend_d;
      tmo_cnt_q   <= tmo_cnt_d;
      flush_lat_q <= flush_lat_d;
      word_q      <= word_d;
      keep_q      <= keep_d;
      m_valid_q   <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench: byte FIFO model feeding the reader, expected words
// built by chunking the pushed byte stream.
`timescale 1ns/1ps
module tb_fifo_word_reader;
  import fifo_word_reader_pkg::*;

  localparam int unsigned BYTES   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TCW     = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  fifo_word_reader #(.BYTES(BYTES), .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte FIFO model
  logic [7:0]  fq[$];
  logic        push_en = 1'b0;
  logic [7:0]  push_data = 8'h00;
  int unsigned cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      fq.delete();
    end else begin
      if (fifo_rd && fq.size() != 0) fifo_data <= fq.pop_front();
      if (push_en && fq.size() < FIFO_DEPTH) fq.push_back(push_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Downstream ready: fixed or randomized
  logic rand_ready = 1'b0;
  logic ready_fix  = 1'b1;
  logic rnd_bit    = 1'b1;
  always @(posedge clk) begin
    #2;
    rnd_bit = ($urandom_range(9) < 7);
  end
  assign m_ready = rand_ready ? rnd_bit : ready_fix;

  // Expected word stream
  logic [31:0] exp_data [0:4095];
  logic [3:0]  exp_keep [0:4095];
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;
  logic [7:0]  acc[$];

  // Monitor state
  int unsigned rd_cnt = 0, valid_cnt = 0, rd_empty_viol = 0, rd_in_out_viol = 0, hold_viol = 0;
  int unsigned last_cap = 0, last_rise = 0, n_rise = 0;
  int unsigned rise_cyc [0:4095];
  logic        prev_hold = 1'b0, prev_valid = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_keep = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_rd     = exp_wr;
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (fifo_rd && fifo_empty) rd_empty_viol++;
      if (fifo_rd && !fifo_empty) begin
        rd_cnt++;
        last_cap = cyc + 2;
      end
      if (m_valid) valid_cnt++;
      if (m_valid && fifo_rd) rd_in_out_viol++;
      if (m_valid && !prev_valid) begin
        last_rise = cyc;
        rise_cyc[n_rise] = cyc;
        n_rise++;
      end
      if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data || m_keep !== prev_keep))
        hold_viol++;
      prev_hold  = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      prev_valid = m_valid;
      if (m_valid && m_ready) begin
        if (exp_rd == exp_wr) begin
          check("extra_word", 64'({m_keep, m_data}), 64'(0));
        end else begin
          check("word_data", 64'(m_data), 64'(exp_data[exp_rd]));
          check("word_keep", 64'(m_keep), 64'(exp_keep[exp_rd]));
          exp_rd++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic emit_acc();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < acc.size(); i++) d = d | (32'(acc[i]) << (8 * i));
    exp_data[exp_wr] = d;
    exp_keep[exp_wr] = 4'((1 << acc.size()) - 1);
    exp_wr++;
    acc.delete();
  endtask

  task automatic end_burst();
    if (acc.size() != 0) emit_acc();
  endtask

  task automatic push_byte(input logic [7:0] b, input bit model);
    int guard;
    guard = 0;
    while (fq.size() >= FIFO_DEPTH && guard < 500) begin
      step();
      guard++;
    end
    if (guard >= 500) check("push_stall", 64'(fq.size()), 64'(0));
    push_en   = 1'b1;
    push_data = b;
    step();
    push_en = 1'b0;
    if (model) begin
      acc.push_back(b);
      if (acc.size() == BYTES) emit_acc();
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (exp_rd != exp_wr && guard < 400) begin
      step();
      guard++;
    end
    check(tag, 64'(exp_wr - exp_rd), 64'(0));
  endtask

  task automatic wait_read(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (fifo_rd && !fifo_empty) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0, v0, r0, n;
    rst   = 1'b1;
    flush = 1'b0;
    repeat (3) step();
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_keep",  64'(m_keep),  64'(0));
    check("rst_m_data",  64'(m_data),  64'(0));
    check("rst_fifo_rd", 64'(fifo_rd), 64'(0));
    rst = 1'b0;
    step();

    // Single full word
    b0 = rd_cnt; v0 = valid_cnt;
    push_byte(8'h11, 1); push_byte(8'h22, 1); push_byte(8'h33, 1); push_byte(8'h44, 1);
    end_burst();
    wait_drain("t1_drain");
    repeat (3) step();
    check("t1_rd_pulses", 64'(rd_cnt - b0), 64'(4));
    check("t1_valid_cycles", 64'(valid_cnt - v0), 64'(1));

    // Backpressure holds word, FIFO keeps the rest
    ready_fix = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1);
    repeat (20) step();
    check("t2_hold_valid", 64'(m_valid), 64'(1));
    check("t2_hold_data",  64'(m_data),  64'(32'h04030201));
    check("t2_hold_keep",  64'(m_keep),  64'(4'hF));
    check("t2_fifo_left",  64'(fq.size()), 64'(4));
    ready_fix = 1'b1;
    end_burst();
    wait_drain("t2_drain");
    repeat (3) step();

    // Idle timeout emits partial word
    push_byte(8'hAA, 1); push_byte(8'hBB, 1);
    end_burst();
    wait_drain("t3_drain");
    check("t3_timeout_latency", 64'(last_rise - last_cap), 64'(TIMEOUT));
    repeat (3) step();

    // Flush while the read is still in flight
    push_byte(8'h5A, 1);
    wait_read("t4_read_seen");
    flush = 1'b1;
    step();
    flush = 1'b0;
    end_burst();
    wait_drain("t4_drain");
    check("t4_flush_before_timeout", 64'(last_rise - last_cap < TIMEOUT), 64'(1));
    repeat (3) step();

    // Reset while a word is held in OUT
    ready_fix = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'hC1 + 8'(i), 0);
    for (int i = 0; i < 20 && !m_valid; i++) step();
    check("t5_out_reached", 64'(m_valid), 64'(1));
    rst = 1'b1;
    step();
    check("t5_rst_valid", 64'(m_valid), 64'(0));
    check("t5_rst_keep",  64'(m_keep),  64'(0));
    check("t5_rst_rd",    64'(fifo_rd), 64'(0));
    rst = 1'b0;
    acc.delete();
    ready_fix = 1'b1;
    step();

    // Reset while a read is pending; byte must be discarded
    push_byte(8'hD1, 0);
    wait_read("t5_read_seen");
    rst = 1'b1;
    step();
    check("t5p_rst_valid", 64'(m_valid), 64'(0));
    check("t5p_rst_keep",  64'(m_keep),  64'(0));
    check("t5p_rst_rd",    64'(fifo_rd), 64'(0));
    rst = 1'b0;
    acc.delete();
    step();
    for (int i = 0; i < 4; i++) push_byte(8'hE1 + 8'(i), 1);
    end_burst();
    wait_drain("t5_restart_drain");
    repeat (3) step();

    // Empty FIFO: nothing moves, flush is harmless
    b0 = rd_cnt; v0 = valid_cnt;
    repeat (100) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (30) step();
    check("t6_no_reads", 64'(rd_cnt - b0), 64'(0));
    check("t6_no_valid", 64'(valid_cnt - v0), 64'(0));

    // Throughput with a continuously non-empty FIFO
    r0 = n_rise;
    for (int i = 0; i < 12; i++) push_byte(8'($urandom), 1);
    end_burst();
    wait_drain("t7_drain");
    check("t7_period_a", 64'(rise_cyc[r0 + 1] - rise_cyc[r0]),     64'(BYTES + 2));
    check("t7_period_b", 64'(rise_cyc[r0 + 2] - rise_cyc[r0 + 1]), 64'(BYTES + 2));
    repeat (3) step();

    // Randomized bursts with random backpressure and flushes
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(11, 1);
      for (int i = 0; i < int'(n); i++) begin
        push_byte(8'($urandom), 1);
        repeat ($urandom_range(2)) step();
      end
      if ($urandom_range(1) == 1) begin
        for (int g = 0; g < 300 && fq.size() != 0; g++) step();
        repeat ($urandom_range(4)) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      end_burst();
      wait_drain("rand_drain");
    end
    rand_ready = 1'b0;
    ready_fix  = 1'b1;
    repeat (40) step();

    check("no_rd_when_empty", 64'(rd_empty_viol),  64'(0));
    check("no_rd_in_out",     64'(rd_in_out_viol), 64'(0));
    check("out_hold_stable",  64'(hold_viol),      64'(0));
    check("all_words_seen",   64'(exp_wr - exp_rd), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
